// File: rtl/at86rf215_rx_stream_fifo.sv
// at86rf215_rx_stream_fifo
// Receive-sample buffer between the AT86RF215 deserialiser and the AXI4-Stream
// DMA path. The write side cannot be back-pressured: samples arriving while full
// are dropped and accounted for. The read side is first-word-fall-through.
module at86rf215_rx_stream_fifo #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DEPTH              = 16,
    parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
    parameter int unsigned DROP_CNT_WIDTH     = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      wr_valid,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_last,
    input  logic                      flush,
    input  logic                      clear_stats,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

    localparam logic [CNT_W-1:0]          CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]          CNT_AFULL = CNT_W'(ALMOST_FULL_LEVEL);
    localparam logic [CNT_W-1:0]          CNT_AEMPTY = CNT_W'(ALMOST_EMPTY_LEVEL);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX  = '1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    logic pop;
    logic push;
    logic drop;

    // Handshake decisions; a flush cycle swallows the write without counting a drop.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = (count != '0) && m_axis_tready;
        if (!flush) begin
            push = wr_valid && ((count != CNT_DEPTH) || pop);
            drop = wr_valid && !push;
        end
    end

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop statistics; a drop coinciding with clear_stats is still recorded.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_stats) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head[DATA_WIDTH];
    assign level         = count;
    assign almost_full   = (count >= CNT_AFULL);
    assign almost_empty  = (count <= CNT_AEMPTY);

endmodule

// File: doc/at86rf215_rx_stream_fifo.md
# at86rf215_rx_stream_fifo

Parametrised receive-sample buffer between the AT86RF215 deserialiser and the AXI4-Stream DMA path. Accepts one sample per cycle from a source that cannot be back-pressured and presents it on an AXI4-Stream master port in first-word-fall-through order. Adds frame-marker passthrough, programmable almost-full/almost-empty flags, an occupancy level, sticky overflow and a saturating drop counter, and a synchronous flush.

## Interface
- DATA_WIDTH, 32: sample width in bits.
- DEPTH, 16: entries; power of two, ≥ 2.
- ALMOST_FULL_LEVEL, DEPTH-2: almost_full asserts when level ≥ this; range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2: almost_empty asserts when level ≤ this; range 0..DEPTH-1.
- DROP_CNT_WIDTH, 16: drop counter width.

- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  sample present this cycle; no back-pressure.
- wr_data  in  DATA_WIDTH  sample.
- wr_last  in  1  last sample of a frame; stored with the sample.
- flush  in  1  synchronous discard of all contents.
- clear_stats  in  1  synchronous clear of overflow and drop_count.
- m_axis_tvalid  out  1  head entry valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tdata  out  DATA_WIDTH  head sample.
- m_axis_tlast  out  1  head frame marker.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  level ≥ ALMOST_FULL_LEVEL.
- almost_empty  out  1  level ≤ ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky; a sample was dropped.
- drop_count  out  DROP_CNT_WIDTH  samples dropped, saturating.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) array holding {last, data}; array contents are not reset.
- Pointers: wr_ptr, rd_ptr, $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register of $clog2(DEPTH)+1 bits, level = count.
- pop = m_axis_tvalid && m_axis_tready.
- push = wr_valid && (count < DEPTH || pop): a full FIFO accepts a write in the same cycle it is popped.
- drop = wr_valid && !push: sample discarded, no pointer/memory change.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither; never under/overflows.
- m_axis_tvalid = (count ≠ 0); m_axis_tdata/tlast = array[rd_ptr] (combinational read, FWFT).
- almost_full, almost_empty: combinational from count.
- overflow: set on drop; cleared by clear_stats; drop in the same cycle as clear_stats wins (overflow=1, drop_count=1).
- drop_count: +1 per drop, holds at 2^DROP_CNT_WIDTH−1; cleared by clear_stats with the rule above.
- flush: next cycle pointers=0, count=0; a wr_valid in the flush cycle is discarded and not counted as a drop; a pop in the flush cycle is honoured by the consumer but has no further effect; statistics unaffected.
- AXI rules: once tvalid is high it stays high with stable tdata/tlast until pop, except on flush or reset.

## Timing
- Reset (areset high, asynchronous): wr_ptr=rd_ptr=count=0; m_axis_tvalid=0, level=0, almost_full=(ALMOST_FULL_LEVEL==0 ⇒ never; i.e. 0), almost_empty=1, overflow=0, drop_count=0. m_axis_tdata/tlast undefined while empty. Reset mid-frame discards all contents.
- Write-to-output latency: 1 cycle; sample pushed at edge N is on m_axis_tdata with tvalid=1 after edge N.
- Throughput: 1 push and 1 pop per cycle sustained, including at full and at level 1.
- Flag/level outputs reflect the count after each edge, no extra latency.
- Combinational paths: m_axis_tready → push decision only (internal); no combinational input-to-output path except through registers.

## Test plan
- Reset then 3 writes 0xA1,0xA2,0xA3 (last on 0xA3), tready=0 → tvalid=1 one cycle after first write, level=3, tdata=0xA1; tready=1 for 3 cycles → 0xA1,0xA2,0xA3 with tlast only on 0xA3, then tvalid=0, almost_empty=1.
- DEPTH=16: 16 writes, tready=0 → level=16, almost_full=1 from level 14; 17th write → overflow=1, drop_count=1, contents unchanged; 20 writes continuously with simultaneous tready=1 at full → no further drops, level stays 16, data order intact across pointer wrap.
- DROP_CNT_WIDTH=4, full FIFO, 20 further writes → drop_count saturates at 15; clear_stats with simultaneous drop → overflow=1, drop_count=1; clear_stats alone → both 0.
- Level 5 with tvalid stalled, assert flush concurrent with wr_valid → next cycle level=0, tvalid=0, drop_count unchanged; following write 0xB0 appears one cycle later as head.
- Continuous write + continuous tready=1 for 1000 cycles, random data → output matches input sequence exactly, level never exceeds 1.
- Assert areset asynchronously mid-burst at level 7 → outputs return to reset values immediately, no output beats after deassertion until new writes.
